aes_inv_block_seq: RTL

- Sequencer directly upstream and downstream of the inverse AES core (aes_inv_cipher_top); the core itself is instantiated outside this block.
- Accepts a 128-bit key and 512-bit ciphertext words over valid/ready.
- Splits each word into four 128-bit blocks and drives the core's kld/ld/done handshake for each block.
- Reassembles the four decrypted blocks into a 512-bit plaintext word on a valid/ready output.

---
 rtl/aes_inv_block_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/aes_inv_block_seq.sv
// aes_inv_block_seq: splits 512-bit ciphertext words into four blocks for the inverse AES core and reassembles the plaintext
module aes_inv_block_seq #(
  parameter int KEY_WAIT = 12,
  parameter int TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [511:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [511:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         core_kld,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  output logic         err
);
  localparam int CW = $clog2((KEY_WAIT > TIMEOUT ? KEY_WAIT : TIMEOUT) + 1);
  typedef enum logic [2:0] {S_IDLE, S_KEY_LD, S_KEY_WT, S_WAIT_IN, S_LOAD, S_RUN, S_OUT} state_t;
  state_t state_q, state_d;
  logic [127:0] key_q, key_d, text_q, text_d;
  logic [511:0] buf_q, buf_d, m_data_q, m_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d, idx_n;
  logic key_loaded_q, key_loaded_d, kld_q, kld_d, ld_q, ld_d;
  logic m_valid_q, m_valid_d, err_q, err_d;
  logic key_rdy_q, key_rdy_d, s_rdy_q, s_rdy_d;
  logic key_hs, s_hs;
  assign key_ready    = key_rdy_q;
  // a pending key always wins over a pending data word
  assign s_ready      = s_rdy_q & ~key_valid;
  assign key_hs       = key_valid & key_ready;
  assign s_hs         = s_valid & s_ready;
  assign idx_n        = idx_q + 2'd1;
  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign core_kld     = kld_q;
  assign core_ld      = ld_q;
  assign core_key     = key_q;
  assign core_text_in = text_q;
  assign err          = err_q;
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    text_d       = text_q;
    buf_d        = buf_q;
    m_data_d     = m_data_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    key_loaded_d = key_loaded_q;
    m_valid_d    = m_valid_q;
    kld_d        = 1'b0;
    ld_d         = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: if (key_hs) begin
        key_d   = key_in;
        kld_d   = 1'b1;
        state_d = S_KEY_LD;
      end
      S_KEY_LD: begin
        key_loaded_d = 1'b0;
        cnt_d        = CW'(KEY_WAIT);
        state_d      = S_KEY_WT;
      end
      S_KEY_WT: if (cnt_q == '0) begin
        key_loaded_d = 1'b1;
        state_d      = S_WAIT_IN;
      end else cnt_d = cnt_q - CW'(1);
      S_WAIT_IN: if (key_hs) begin
        key_d   = key_in;
        kld_d   = 1'b1;
        state_d = S_KEY_LD;
      end else if (s_hs) begin
        buf_d   = s_data;
        idx_d   = 2'd0;
        text_d  = s_data[511:384];
        ld_d    = 1'b1;
        state_d = S_LOAD;
      end
      // counter expiring at zero puts err exactly TIMEOUT cycles after core_ld
      S_LOAD: begin
        cnt_d   = CW'(TIMEOUT - 2);
        state_d = S_RUN;
      end
      S_RUN: if (core_done) begin
        m_data_d[{~idx_q, 7'd0} +: 128] = core_text_out;
        if (idx_q == 2'd3) begin
          m_valid_d = 1'b1;
          state_d   = S_OUT;
        end else begin
          idx_d   = idx_n;
          text_d  = buf_q[{~idx_n, 7'd0} +: 128];
          ld_d    = 1'b1;
          state_d = S_LOAD;
        end
      end else if (cnt_q == '0) begin
        err_d    = 1'b1;
        m_data_d = '0;
        state_d  = S_WAIT_IN;
      end else cnt_d = cnt_q - CW'(1);
      S_OUT: if (m_ready) begin
        m_valid_d = 1'b0;
        state_d   = S_WAIT_IN;
      end
      default: state_d = S_IDLE;
    endcase
    key_rdy_d = (state_d == S_IDLE) | (state_d == S_WAIT_IN);
    s_rdy_d   = (state_d == S_WAIT_IN) & key_loaded_d;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      text_q       <= '0;
      buf_q        <= '0;
      m_data_q     <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      key_loaded_q <= 1'b0;
      m_valid_q    <= 1'b0;
      kld_q        <= 1'b0;
      ld_q         <= 1'b0;
      err_q        <= 1'b0;
      key_rdy_q    <= 1'b0;
      s_rdy_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      text_q       <= text_d;
      buf_q        <= buf_d;
      m_data_q     <= m_data_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      key_loaded_q <= key_loaded_d;
      m_valid_q    <= m_valid_d;
      kld_q        <= kld_d;
      ld_q         <= ld_d;
      err_q        <= err_d;
      key_rdy_q    <= key_rdy_d;
      s_rdy_q      <= s_rdy_d;
    end
endmodule
